// File: rtl/host_io_port_pkg.sv
// Shared sizing defaults, input-FSM encoding and CPU register address constants.
package host_io_port_pkg;

  localparam int DEFAULT_DATA_SIZE  = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // CPU move-instruction addresses that the ack/write strobes correspond to.
  localparam logic [8:0] IN_REG_SRC   = 9'b000100101;
  localparam logic [6:0] OUT_REG_DEST = 7'b0100110;

  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_HELD  = 1'b1
  } in_state_e;

endpackage

// File: rtl/host_io_port_io_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module io_fifo
  import host_io_port_pkg::*;
#(
  parameter int Data_Size  = DEFAULT_DATA_SIZE,
  parameter int FIFO_Depth = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [Data_Size-1:0] din_i,
  input  logic                 pop_i,
  output logic [Data_Size-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(FIFO_Depth);

  logic [Data_Size-1:0] mem_q [FIFO_Depth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(FIFO_Depth));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !rst;
  assign do_push = push_i && (!full_o || do_pop) && !rst;

  // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/host_io_port.sv
// Host <-> CPU I/O port: input FIFO feeding a held CPU In_Reg with a one-cycle
// stall pulse per load, and an output FIFO collecting CPU Out_Reg writes.
module host_io_port
  import host_io_port_pkg::*;
#(
  parameter int Data_Size  = DEFAULT_DATA_SIZE,
  parameter int FIFO_Depth = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Data_Size-1:0] host_in_data,
  input  logic                 host_in_valid,
  output logic                 host_in_ready,
  output logic [Data_Size-1:0] host_out_data,
  output logic                 host_out_valid,
  input  logic                 host_out_ready,
  output logic [Data_Size-1:0] cpu_in_reg,
  output logic                 cpu_override_stall,
  input  logic                 cpu_in_ack,
  input  logic [Data_Size-1:0] cpu_out_reg,
  input  logic                 cpu_out_wr,
  output logic                 cpu_in_valid,
  output logic                 out_overflow
);

  in_state_e            state_q, state_d;
  logic [Data_Size-1:0] in_reg_q, in_reg_d;
  logic                 stall_q, stall_d;
  logic                 ovf_q, ovf_d;

  logic                 in_full, in_empty, in_push, in_pop;
  logic [Data_Size-1:0] in_head;
  logic                 out_full, out_empty, out_pop;

  assign host_in_ready  = !rst && !in_full;
  assign in_push        = host_in_valid && host_in_ready;
  assign host_out_valid = !rst && !out_empty;
  assign out_pop        = host_out_valid && host_out_ready;

  assign cpu_in_reg         = in_reg_q;
  assign cpu_override_stall = stall_q;
  assign cpu_in_valid       = (state_q == IN_HELD);
  assign out_overflow       = ovf_q;

  io_fifo #(.Data_Size(Data_Size), .FIFO_Depth(FIFO_Depth)) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_push),
    .din_i   (host_in_data),
    .pop_i   (in_pop),
    .dout_o  (in_head),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  io_fifo #(.Data_Size(Data_Size), .FIFO_Depth(FIFO_Depth)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cpu_out_wr),
    .din_i   (cpu_out_reg),
    .pop_i   (out_pop),
    .dout_o  (host_out_data),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  // Input FSM: load In_Reg when idle or when the CPU consumed the held word.
  always_comb begin
    state_d  = state_q;
    in_reg_d = in_reg_q;
    in_pop   = 1'b0;
    case (state_q)
      IN_EMPTY: begin
        if (!in_empty) begin
          in_pop  = 1'b1;
          state_d = IN_HELD;
        end
      end
      IN_HELD: begin
        if (cpu_in_ack) begin
          if (!in_empty) in_pop = 1'b1;
          else           state_d = IN_EMPTY;
        end
      end
      default: state_d = IN_EMPTY;
    endcase
    if (in_pop) in_reg_d = in_head;
    stall_d = in_pop;
    // A full output FIFO drops the word unless the host frees a slot this cycle.
    ovf_d = ovf_q | (cpu_out_wr && out_full && !out_pop);
  end

  // State, In_Reg, stall pulse and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IN_EMPTY;
      in_reg_q <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_reg_q <= in_reg_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_host_io_port.sv
// Self-checking bench for host_io_port using expected-word queues.
module tb_host_io_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] host_in_data = '0;
  logic        host_in_valid = 1'b0;
  logic        host_in_ready;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready = 1'b0;
  logic [15:0] cpu_in_reg;
  logic        cpu_override_stall;
  logic        cpu_in_ack = 1'b0;
  logic [15:0] cpu_out_reg = '0;
  logic        cpu_out_wr = 1'b0;
  logic        cpu_in_valid;
  logic        out_overflow;

  int errors = 0;
  int checks = 0;
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  logic [15:0] exp_w;

  host_io_port #(.Data_Size(16), .FIFO_Depth(4)) dut (
    .clk(clk), .rst(rst),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .cpu_in_reg(cpu_in_reg), .cpu_override_stall(cpu_override_stall), .cpu_in_ack(cpu_in_ack),
    .cpu_out_reg(cpu_out_reg), .cpu_out_wr(cpu_out_wr), .cpu_in_valid(cpu_in_valid),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (host_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", host_in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (cpu_in_reg !== 16'h0) begin errors++; $display("FAIL rst_in_reg got=%h exp=0000", cpu_in_reg); end
    checks++; if ({cpu_override_stall, cpu_in_valid, out_overflow, host_out_valid} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got=%b exp=0000", {cpu_override_stall, cpu_in_valid, out_overflow, host_out_valid}); end
    checks++; if (host_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", host_in_ready); end
  endtask

  task automatic test_single();
    host_in_data = 16'h1234; host_in_valid = 1'b1; in_q.push_back(16'h1234);
    tick();
    host_in_valid = 1'b0;
    checks++; if ({cpu_in_valid, cpu_override_stall} !== 2'b00) begin
      errors++; $display("FAIL single_early got=%b exp=00", {cpu_in_valid, cpu_override_stall}); end
    tick();
    exp_w = in_q.pop_front();
    checks++; if (cpu_in_reg !== exp_w) begin errors++; $display("FAIL single_data got=%h exp=%h", cpu_in_reg, exp_w); end
    checks++; if ({cpu_in_valid, cpu_override_stall} !== 2'b11) begin
      errors++; $display("FAIL single_valid_stall got=%b exp=11", {cpu_in_valid, cpu_override_stall}); end
    tick();
    checks++; if (cpu_override_stall !== 1'b0) begin errors++; $display("FAIL single_stall_len got=%b exp=0", cpu_override_stall); end
    cpu_in_ack = 1'b1;
    tick();
    cpu_in_ack = 1'b0;
    checks++; if (cpu_in_valid !== 1'b0 || cpu_in_reg !== 16'h1234) begin
      errors++; $display("FAIL single_release got=%b/%h exp=0/1234", cpu_in_valid, cpu_in_reg); end
  endtask

  task automatic test_ack_empty();
    cpu_in_ack = 1'b1;
    tick();
    checks++; if ({cpu_in_valid, cpu_override_stall} !== 2'b00 || cpu_in_reg !== 16'h1234) begin
      errors++; $display("FAIL ack_empty got=%b%b/%h exp=00/1234", cpu_in_valid, cpu_override_stall, cpu_in_reg); end
    tick();
    cpu_in_ack = 1'b0;
    checks++; if ({cpu_in_valid, cpu_override_stall} !== 2'b00) begin
      errors++; $display("FAIL ack_empty2 got=%b exp=00", {cpu_in_valid, cpu_override_stall}); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      host_in_data = 16'(i); host_in_valid = 1'b1;
      checks++; if (host_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", i, host_in_ready); end
      in_q.push_back(16'(i));
      tick();
    end
    host_in_valid = 1'b0;
    checks++; if (host_in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%b exp=0", host_in_ready); end
    exp_w = in_q.pop_front();
    checks++; if (cpu_in_reg !== exp_w || cpu_in_valid !== 1'b1) begin
      errors++; $display("FAIL fill_head got=%h/%b exp=%h/1", cpu_in_reg, cpu_in_valid, exp_w); end
    for (int i = 0; i < 4; i++) begin
      cpu_in_ack = 1'b1;
      tick();
      cpu_in_ack = 1'b0;
      exp_w = in_q.pop_front();
      checks++; if (cpu_in_reg !== exp_w || cpu_override_stall !== 1'b1) begin
        errors++; $display("FAIL fill_word_%0d got=%h/%b exp=%h/1", i, cpu_in_reg, cpu_override_stall, exp_w); end
      checks++; if (host_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_%0d got=%b exp=1", i, host_in_ready); end
      tick();
      checks++; if (cpu_override_stall !== 1'b0) begin errors++; $display("FAIL fill_stall_len_%0d got=%b exp=0", i, cpu_override_stall); end
    end
    cpu_in_ack = 1'b1;
    tick();
    cpu_in_ack = 1'b0;
    checks++; if (cpu_in_valid !== 1'b0 || cpu_in_reg !== 16'h0005) begin
      errors++; $display("FAIL fill_drained got=%b/%h exp=0/0005", cpu_in_valid, cpu_in_reg); end
  endtask

  task automatic test_overflow();
    host_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_out_reg = 16'hA0 + 16'(i); cpu_out_wr = 1'b1;
      if (i < 4) out_q.push_back(16'hA0 + 16'(i));
      if (i == 4) begin
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", out_overflow); end
      end
      tick();
    end
    cpu_out_wr = 1'b0;
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", out_overflow); end
    host_out_ready = 1'b1;
    while (out_q.size() > 0) begin
      exp_w = out_q.pop_front();
      checks++; if (host_out_valid !== 1'b1 || host_out_data !== exp_w) begin
        errors++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", host_out_valid, host_out_data, exp_w); end
      tick();
    end
    host_out_ready = 1'b0;
    checks++; if (host_out_valid !== 1'b0 || out_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after_drain got=%b/%b exp=0/1", host_out_valid, out_overflow); end
  endtask

  task automatic test_full_pushpop();
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", out_overflow); end
    for (int i = 0; i < 4; i++) begin
      cpu_out_reg = 16'hB0 + 16'(i); cpu_out_wr = 1'b1; out_q.push_back(16'hB0 + 16'(i));
      tick();
    end
    cpu_out_reg = 16'hB4; host_out_ready = 1'b1;
    exp_w = out_q.pop_front();
    checks++; if (host_out_data !== exp_w) begin errors++; $display("FAIL pp_head got=%h exp=%h", host_out_data, exp_w); end
    out_q.push_back(16'hB4);
    tick();
    cpu_out_wr = 1'b0; host_out_ready = 1'b0;
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", out_overflow); end
    host_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = out_q.pop_front();
      checks++; if (host_out_valid !== 1'b1 || host_out_data !== exp_w) begin
        errors++; $display("FAIL pp_drain_%0d got=%b/%h exp=1/%h", i, host_out_valid, host_out_data, exp_w); end
      tick();
    end
    host_out_ready = 1'b0;
    checks++; if (host_out_valid !== 1'b0) begin errors++; $display("FAIL pp_count got=%b exp=0", host_out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      host_in_data = 16'h70 + 16'(i); host_in_valid = 1'b1;
      cpu_out_reg = 16'hC0 + 16'(i); cpu_out_wr = (i < 2);
      tick();
    end
    rst = 1'b1;
    host_in_valid = 1'b1; cpu_out_wr = 1'b1; cpu_in_ack = 1'b1; host_out_ready = 1'b1;
    tick();
    checks++; if (cpu_in_reg !== 16'h0 || {cpu_override_stall, cpu_in_valid, out_overflow, host_out_valid, host_in_ready} !== 5'b0) begin
      errors++; $display("FAIL mid_reset got=%h/%b exp=0000/00000", cpu_in_reg,
        {cpu_override_stall, cpu_in_valid, out_overflow, host_out_valid, host_in_ready}); end
    rst = 1'b0; host_in_valid = 1'b0; cpu_out_wr = 1'b0; cpu_in_ack = 1'b0; host_out_ready = 1'b0;
    in_q.delete(); out_q.delete();
    host_in_data = 16'hBEEF; host_in_valid = 1'b1; in_q.push_back(16'hBEEF);
    cpu_out_reg = 16'hC5; cpu_out_wr = 1'b1; out_q.push_back(16'hC5);
    tick();
    host_in_valid = 1'b0; cpu_out_wr = 1'b0;
    exp_w = out_q.pop_front();
    checks++; if (host_out_valid !== 1'b1 || host_out_data !== exp_w) begin
      errors++; $display("FAIL mid_out got=%b/%h exp=1/%h", host_out_valid, host_out_data, exp_w); end
    tick();
    exp_w = in_q.pop_front();
    checks++; if (cpu_in_reg !== exp_w || {cpu_in_valid, cpu_override_stall} !== 2'b11) begin
      errors++; $display("FAIL mid_in got=%h/%b exp=%h/11", cpu_in_reg, {cpu_in_valid, cpu_override_stall}, exp_w); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ack_empty();
    test_fill();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_io_port.md
HOST_IO_PORT -- requirements
Module: host_io_port

Interface
- REQ-001: Parameter Data_Size, default 16, width of all data paths.
- REQ-002: Parameter FIFO_Depth, default 4, entries per FIFO; power of two, at least 2.
- REQ-003: clk  input  1  single clock; all state updates on posedge clk.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: host_in_data  input  Data_Size  word from host toward CPU.
- REQ-006: host_in_valid  input  1  host_in_data is valid.
- REQ-007: host_in_ready  output  1  input FIFO can accept a word.
- REQ-008: host_out_data  output  Data_Size  head word of the output FIFO.
- REQ-009: host_out_valid  output  1  output FIFO is non-empty.
- REQ-010: host_out_ready  input  1  host consumes host_out_data.
- REQ-011: cpu_in_reg  output  Data_Size  drives the CPU In_Reg source port.
- REQ-012: cpu_override_stall  output  1  drives the CPU Override_Stall input.
- REQ-013: cpu_in_ack  input  1  CPU executed a move whose source is In_Reg (src == 9'b000100101) this cycle.
- REQ-014: cpu_out_reg  input  Data_Size  CPU Out_Reg value.
- REQ-015: cpu_out_wr  input  1  CPU executed a move to Out_Reg (dest == 7'b0100110) this cycle; cpu_out_reg holds the new value.
- REQ-016: cpu_in_valid  output  1  cpu_in_reg holds an unconsumed word.
- REQ-017: out_overflow  output  1  sticky flag: a CPU output word was dropped.

Function
- REQ-018: An input push SHALL occur when host_in_valid && host_in_ready; host_in_ready = !in_fifo_full.
- REQ-019: The input-side FSM SHALL have states IN_EMPTY and IN_HELD.
  - IN_EMPTY with the input FIFO non-empty: pop the FIFO into cpu_in_reg, go to IN_HELD.
  - IN_HELD with cpu_in_ack and the FIFO non-empty: pop the next word into cpu_in_reg, stay in IN_HELD.
  - IN_HELD with cpu_in_ack and the FIFO empty: go to IN_EMPTY; cpu_in_reg keeps its last value.
- REQ-020: cpu_override_stall SHALL be high for exactly the one cycle following each edge that loads cpu_in_reg, and low otherwise.
- REQ-021: Input latency: a word pushed at edge k into an empty FIFO in state IN_EMPTY SHALL appear on cpu_in_reg after edge k+1.
- REQ-022: cpu_in_valid SHALL be high exactly when the state is IN_HELD.
- REQ-023: cpu_in_ack in IN_EMPTY SHALL be ignored.
- REQ-024: A host push and an FSM pop in the same cycle SHALL both take effect, with the FIFO count unchanged.
- REQ-025: An output push SHALL occur on cpu_out_wr, capturing cpu_out_reg.
- REQ-026: An output pop SHALL occur on host_out_valid && host_out_ready.
- REQ-027: The output FIFO SHALL be first-word-fall-through; host_out_data is the head word whenever host_out_valid is high.
- REQ-028: cpu_out_wr with the output FIFO full and no same-cycle pop:
  - the word SHALL be dropped;
  - out_overflow SHALL be set;
  - FIFO contents SHALL be unchanged.
- REQ-029: cpu_out_wr with the output FIFO full and a same-cycle pop SHALL be accepted.
- REQ-030: out_overflow SHALL clear only on rst.
- REQ-031: Both FIFOs SHALL preserve word order; read and write pointers SHALL wrap modulo FIFO_Depth.

Reset
- REQ-032: On rst, the following SHALL be forced within one clock edge, regardless of in-flight handshakes:
  - both FIFOs empty (pointers and counts 0);
  - FSM state IN_EMPTY;
  - cpu_in_reg = 0;
  - cpu_override_stall = 0, cpu_in_valid = 0, out_overflow = 0.
- REQ-033: While rst is high, host_in_ready and host_out_valid SHALL be 0, and pushes and pops SHALL be ignored.

Structure
- REQ-034: Defaults for Data_Size and FIFO_Depth, the IN_EMPTY/IN_HELD encodings, and the In_Reg/Out_Reg address constants SHALL live in the shared package.
- REQ-035: A single sub-module io_fifo (synchronous FWFT FIFO with full/empty flags) SHALL be instantiated twice, once for input and once for output.

Verification
- REQ-036: Reset, then push 16'h1234 at edge k -> after edge k+1: cpu_in_reg = 16'h1234, cpu_override_stall high for one cycle, cpu_in_valid = 1.
- REQ-037: Push 16'h0001..16'h0005 with no cpu_in_ack -> host_in_ready = 0 after the 5th accepted word (4 in FIFO plus 1 held); each cpu_in_ack then presents 16'h0002..16'h0005 in order, with one stall pulse per word.
- REQ-038: cpu_in_ack while IN_EMPTY -> no state change and no stall pulse; cpu_in_reg unchanged.
- REQ-039: Five cpu_out_wr with values 16'hA0..16'hA4 and host_out_ready = 0 -> 16'hA4 dropped, out_overflow = 1; draining yields 16'hA0..16'hA3.
- REQ-040: Output FIFO full with cpu_out_wr and host_out_ready in the same cycle -> no drop, out_overflow stays 0, count stays 4.
- REQ-041: Assert rst mid-transfer (both FIFOs partly full) -> all outputs take their reset values on the next edge; after rst deasserts, the first new push is delivered normally.
